fwd_scoreboard_unit: RTL and testbench

- Parametrised successor to the single-stage EX forwarding path.
- Keeps a registered tag pipeline (scoreboard) of the DEPTH instructions in flight past decode: EX, MEM, WB, ...
- Forwards each source operand from the youngest in-flight producer.
- Raises a load-use stall when that producer's data is not yet available, inserts a bubble, and counts stall cycles.
- Sits between decode/regfile read and the ID/EX register.

---
 rtl/fwd_scoreboard_unit.sv | 102 ++++++++++
 tb/tb_fwd_scoreboard_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: in-flight destination scoreboard that forwards
// operands from the youngest producer and stalls on unready loads.
module fwd_scoreboard_unit #(
  parameter int XLEN = 32,
  parameter int RB = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_READY_STAGE = 1,
  parameter int SELW = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RB-1:0]         id_rs1,
  input  logic [RB-1:0]         id_rs2,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [RB-1:0]         id_rd,
  input  logic                  id_we,
  input  logic                  id_is_load,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  input  logic                  flush,
  output logic [XLEN-1:0]       rs1_fwd,
  output logic [XLEN-1:0]       rs2_fwd,
  output logic [SELW-1:0]       rs1_sel,
  output logic [SELW-1:0]       rs2_sel,
  output logic                  stall,
  output logic [15:0]           stall_count
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] wen;
  logic [DEPTH-1:0] lod;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] m1;
  logic [DEPTH-1:0] m2;
  logic [RB-1:0]    rd_q [DEPTH];
  logic             haz1;
  logic             haz2;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rdy[k] = !lod[k] || (k >= LOAD_READY_STAGE);
      m1[k]  = vld[k] && wen[k] &&
               (rd_q[k] == id_rs1) && (id_rs1 != '0);
      m2[k]  = vld[k] && wen[k] &&
               (rd_q[k] == id_rs2) && (id_rs2 != '0);
    end
  end

  // Scan oldest to youngest so the youngest match lands last.
  always_comb begin
    rs1_fwd = id_rs1_data;
    rs2_fwd = id_rs2_data;
    rs1_sel = '0;
    rs2_sel = '0;
    haz1    = 1'b0;
    haz2    = 1'b0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      if (m1[k]) begin
        rs1_fwd = stage_data[k*XLEN +: XLEN];
        rs1_sel = SELW'(k+1);
        haz1    = !rdy[k];
      end
      if (m2[k]) begin
        rs2_fwd = stage_data[k*XLEN +: XLEN];
        rs2_sel = SELW'(k+1);
        haz2    = !rdy[k];
      end
    end
  end

  assign stall = id_valid && (haz1 || haz2) && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld <= '0;
    end else begin
      vld[0] <= id_valid && !stall;
      for (int k = 1; k < DEPTH; k++)
        vld[k] <= vld[k-1];
    end
  end

  always_ff @(posedge clk) begin
    rd_q[0] <= id_rd;
    wen[0]  <= id_we;
    lod[0]  <= id_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      rd_q[k] <= rd_q[k-1];
      wen[k]  <= wen[k-1];
      lod[k]  <= lod[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Bench for fwd_scoreboard_unit: directed table, random run against
// a queue model, and stall counter saturation on a deep instance.
module tb_fwd_scoreboard_unit;
  localparam int XLEN = 32;
  localparam int RB = 5;
  localparam int D = 3;
  localparam int LRS = 1;
  localparam int SELW = 2;
  localparam int BD = 8;
  localparam int BLRS = 7;
  localparam int BSELW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, id_valid, id_we, id_is_load, flush;
  logic [RB-1:0] id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data;
  logic [D*XLEN-1:0] stage_data;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [SELW-1:0] rs1_sel, rs2_sel;
  logic stall;
  logic [15:0] stall_count;

  logic b_reset, b_valid, b_we, b_ld, b_flush;
  logic [RB-1:0] b_rs1, b_rs2, b_rd;
  logic [XLEN-1:0] b_d1, b_d2;
  logic [BD*XLEN-1:0] b_sd;
  logic [XLEN-1:0] b_f1, b_f2;
  logic [BSELW-1:0] b_s1, b_s2;
  logic b_stall;
  logic [15:0] b_cnt;

  fwd_scoreboard_unit #(
    .XLEN(XLEN), .RB(RB), .DEPTH(D), .LOAD_READY_STAGE(LRS)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .stage_data(stage_data), .flush(flush),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .stall(stall), .stall_count(stall_count)
  );

  fwd_scoreboard_unit #(
    .XLEN(XLEN), .RB(RB), .DEPTH(BD), .LOAD_READY_STAGE(BLRS)
  ) dut_b (
    .clk(clk), .reset(b_reset), .id_valid(b_valid),
    .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_rs1_data(b_d1), .id_rs2_data(b_d2),
    .id_rd(b_rd), .id_we(b_we), .id_is_load(b_ld),
    .stage_data(b_sd), .flush(b_flush),
    .rs1_fwd(b_f1), .rs2_fwd(b_f2),
    .rs1_sel(b_s1), .rs2_sel(b_s2),
    .stall(b_stall), .stall_count(b_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic v; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic we; logic ld; logic fl;
    logic [31:0] d1; logic [31:0] d2; logic [95:0] sd;
    logic [31:0] e1; logic [1:0] s1;
    logic [31:0] e2; logic [1:0] s2;
    logic est; logic [15:0] ecnt;
  } vec_t;

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic we, input logic ld,
    input logic fl, input logic [31:0] d1, input logic [31:0] d2,
    input logic [95:0] sd, input logic [31:0] e1,
    input logic [1:0] s1, input logic [31:0] e2,
    input logic [1:0] s2, input logic est, input logic [15:0] ecnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
    t.we = we; t.ld = ld; t.fl = fl;
    t.d1 = d1; t.d2 = d2; t.sd = sd;
    t.e1 = e1; t.s1 = s1; t.e2 = e2; t.s2 = s2;
    t.est = est; t.ecnt = ecnt;
    return t;
  endfunction

  typedef struct {
    logic v; logic we; logic ld; logic [4:0] rd;
  } ent_t;
  ent_t mq[$];

  function automatic int youngest(input logic [4:0] rs);
    int k = -1;
    for (int i = 0; i < mq.size(); i++)
      if (k < 0 && mq[i].v && mq[i].we &&
          mq[i].rd == rs && rs != 5'd0)
        k = i;
    return k;
  endfunction

  vec_t tbl[15];

  initial begin
    int k1, k2;
    logic est, rdy1, rdy2;
    logic [31:0] e1, e2;
    logic [15:0] mcnt, bcnt;
    ent_t ne;

    tbl[0]  = mk(0,5,0,0,0,0,0,32'hAAAA,0,96'h0,
                 32'hAAAA,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,5,1,0,0,0,0,96'h0,0,0,0,0,0,0);
    tbl[2]  = mk(1,5,6,8,1,0,0,0,32'h66,{64'h0,32'h64},
                 32'h64,1,32'h66,0,0,0);
    tbl[3]  = mk(1,0,0,7,1,1,0,0,0,{64'h0,32'h64},0,0,0,0,0,0);
    tbl[4]  = mk(1,1,7,9,1,0,0,32'h11111111,32'h77,
                 {64'h0,32'h1234},32'h11111111,0,0,1,1,0);
    tbl[5]  = mk(1,1,7,9,1,0,0,32'h11111111,32'h77,
                 {32'h0,32'hDEADBEEF,32'h0},
                 32'h11111111,0,32'hDEADBEEF,2,0,1);
    tbl[6]  = mk(1,0,0,3,1,0,0,0,0,96'h0,0,0,0,0,0,1);
    tbl[7]  = mk(1,0,0,10,1,0,0,0,0,96'h0,0,0,0,0,0,1);
    tbl[8]  = mk(1,0,0,3,1,0,0,0,0,96'h0,0,0,0,0,0,1);
    tbl[9]  = mk(1,3,10,0,1,0,0,32'hAA,32'hBB,
                 {32'h11,32'h99,32'h22},32'h22,1,32'h99,2,0,1);
    tbl[10] = mk(1,0,0,4,0,0,0,0,0,96'h0,0,0,0,0,0,1);
    tbl[11] = mk(1,0,4,11,1,1,0,0,32'h44,
                 {32'h33,32'h55,32'h66},0,0,32'h44,0,0,1);
    tbl[12] = mk(1,11,0,12,1,0,1,32'hC1,0,
                 {64'h0,32'h5555},32'h5555,1,0,0,0,1);
    tbl[13] = mk(1,11,3,0,0,0,0,32'hC1,32'hC3,
                 {32'h1,32'h2,32'h3},32'hC1,0,32'hC3,0,0,1);
    tbl[14] = mk(0,0,0,0,0,0,0,0,0,96'h0,0,0,0,0,0,1);

    b_reset = 1; b_valid = 0; b_we = 0; b_ld = 0; b_flush = 0;
    b_rs1 = 0; b_rs2 = 0; b_rd = 0; b_d1 = 0; b_d2 = 0;
    b_sd = '0;
    reset = 1; id_valid = 0; id_we = 0; id_is_load = 0; flush = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; stage_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      id_valid = tbl[i].v; id_rs1 = tbl[i].rs1;
      id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
      id_we = tbl[i].we; id_is_load = tbl[i].ld;
      flush = tbl[i].fl; id_rs1_data = tbl[i].d1;
      id_rs2_data = tbl[i].d2; stage_data = tbl[i].sd;
      #1;
      chk($sformatf("t%0d rs1_sel", i), 32'(rs1_sel), 32'(tbl[i].s1));
      chk($sformatf("t%0d rs2_sel", i), 32'(rs2_sel), 32'(tbl[i].s2));
      chk($sformatf("t%0d stall", i), 32'(stall), 32'(tbl[i].est));
      chk($sformatf("t%0d count", i), 32'(stall_count),
          32'(tbl[i].ecnt));
      if (!tbl[i].est) begin
        chk($sformatf("t%0d rs1_fwd", i), rs1_fwd, tbl[i].e1);
        chk($sformatf("t%0d rs2_fwd", i), rs2_fwd, tbl[i].e2);
      end
    end

    mq.delete();
    for (int i = 0; i < D; i++) begin
      ne.v = 0; ne.we = 0; ne.ld = 0; ne.rd = 0;
      mq.push_back(ne);
    end
    mcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = (i == 0) || ($urandom_range(99) == 0);
      flush = ($urandom_range(9) == 0);
      id_valid = $urandom_range(1);
      id_rs1 = 5'($urandom_range(3));
      id_rs2 = 5'($urandom_range(3));
      id_rd = 5'($urandom_range(3));
      id_we = ($urandom_range(3) != 0);
      id_is_load = ($urandom_range(4) < 2);
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      stage_data = {$urandom, $urandom, $urandom};
      #1;
      k1 = youngest(id_rs1);
      k2 = youngest(id_rs2);
      e1 = (k1 < 0) ? id_rs1_data : stage_data[k1*32 +: 32];
      e2 = (k2 < 0) ? id_rs2_data : stage_data[k2*32 +: 32];
      rdy1 = (k1 < 0) || !mq[k1].ld || (k1 >= LRS);
      rdy2 = (k2 < 0) || !mq[k2].ld || (k2 >= LRS);
      est = id_valid && !(rdy1 && rdy2) && !flush;
      if (i > 0) begin
        chk("rnd rs1_sel", 32'(rs1_sel), 32'(k1 + 1));
        chk("rnd rs2_sel", 32'(rs2_sel), 32'(k2 + 1));
        chk("rnd stall", 32'(stall), 32'(est));
        chk("rnd count", 32'(stall_count), 32'(mcnt));
        if (!est) begin
          chk("rnd rs1_fwd", rs1_fwd, e1);
          chk("rnd rs2_fwd", rs2_fwd, e2);
        end
      end
      @(posedge clk);
      if (reset || flush) begin
        for (int j = 0; j < D; j++) mq[j].v = 0;
      end else begin
        ne.v = id_valid && !est; ne.we = id_we;
        ne.ld = id_is_load; ne.rd = id_rd;
        mq.push_front(ne);
        void'(mq.pop_back());
      end
      if (reset) mcnt = 0;
      else if (est && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    end
    @(negedge clk);
    reset = 0; flush = 0; id_valid = 0;

    b_reset = 0; b_valid = 1; b_rs1 = 1; b_rs2 = 0; b_rd = 1;
    b_we = 1; b_ld = 1; b_sd = {8{32'hCAFE0000}};
    bcnt = 0;
    for (int i = 0; i < 75000; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      est = (i % 8) != 0;
      if (i < 16 || bcnt >= 16'hFFF0) begin
        chk("sat stall", 32'(b_stall), 32'(est));
        chk("sat count", 32'(b_cnt), 32'(bcnt));
      end
      if (est && bcnt != 16'hFFFF) bcnt = bcnt + 16'd1;
    end
    @(negedge clk);
    #1;
    chk("sat final", 32'(b_cnt), 32'hFFFF);
    b_reset = 1;
    @(negedge clk);
    b_reset = 0;
    #1;
    chk("rst count", 32'(b_cnt), 32'h0);
    chk("rst rs1_sel", 32'(b_s1), 32'h0);
    chk("rst stall", 32'(b_stall), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
